// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and sizing helpers for the bit-serial adder datapath.
package serial_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, SHIFT = 2'd2} state_t;
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/serial_operand_feeder_if.sv
// serial_operand_feeder_if: parallel operand handshake into the serial feeder.
interface serial_operand_feeder_if #(parameter int WIDTH = serial_pkg::DEFAULT_WIDTH);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  modport master(output in_valid, a_in, b_in, input in_ready);
  modport slave(input in_valid, a_in, b_in, output in_ready);
endinterface

// File: rtl/ser_shift_reg.sv
// ser_shift_reg: parallel-load, zero-fill right-shift register.
module ser_shift_reg #(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (load) q <= d;
    else if (shift) q <= q >> 1;
endmodule

// File: rtl/serial_operand_feeder.sv
// serial_operand_feeder: captures an operand pair and streams it LSB-first to a bit-serial adder.
// Define SER_CARRY_FLUSH_EN to append a zero bit cycle that flushes the adder's carry-out.
module serial_operand_feeder
  import serial_pkg::*;
#(parameter int WIDTH = DEFAULT_WIDTH) (
  input  logic clk,
  input  logic reset,
  serial_operand_feeder_if.slave up,
  output logic adder_clr,
  output logic a_ser,
  output logic b_ser,
  output logic ser_valid,
  output logic ser_first,
  output logic ser_last,
  output logic busy
);
  localparam int CW = cnt_width(WIDTH);
`ifdef SER_CARRY_FLUSH_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);
  localparam logic [CW-1:0] PEN = CW'(NBITS - 2);
  localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] qa, qb;
  logic load, shift, more_data;
  assign load = state == IDLE && up.in_valid && up.in_ready;
  assign shift = state == CLEAR || (state == SHIFT && cnt != LAST);
  // Outputs are set on the edge entering each cycle, so the bit shown next is the LSB now.
  assign more_data = state == CLEAR || cnt != DATA_LAST;
  ser_shift_reg #(.WIDTH(WIDTH)) u_a (.clk(clk), .reset(reset), .load(load), .shift(shift), .d(up.a_in), .q(qa));
  ser_shift_reg #(.WIDTH(WIDTH)) u_b (.clk(clk), .reset(reset), .load(load), .shift(shift), .d(up.b_in), .q(qb));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      up.in_ready <= 1'b0;
      adder_clr <= 1'b0;
      a_ser <= 1'b0;
      b_ser <= 1'b0;
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
      ser_last <= 1'b0;
      busy <= 1'b0;
    end else begin
      ser_valid <= shift;
      ser_first <= state == CLEAR;
      ser_last <= state == SHIFT && cnt == PEN;
      a_ser <= shift && more_data && qa[0];
      b_ser <= shift && more_data && qb[0];
      adder_clr <= load;
      case (state)
        IDLE: begin
          state <= load ? CLEAR : IDLE;
          up.in_ready <= !load;
          busy <= load;
        end
        CLEAR: begin
          state <= SHIFT;
          cnt <= '0;
        end
        default: begin
          state <= cnt == LAST ? IDLE : SHIFT;
          cnt <= cnt == LAST ? '0 : cnt + 1'b1;
          up.in_ready <= cnt == LAST;
          busy <= cnt != LAST;
        end
      endcase
    end
endmodule

// File: doc/serial_operand_feeder.md
Name: serial_operand_feeder

Overview:
- Upstream stage for the bit-serial adder.
- Accepts two parallel WIDTH-bit operands through a valid/ready handshake and clears the adder's carry with a one-cycle pulse.
- Then streams both operands LSB-first, one bit pair per clock, with framing flags so the downstream collector can align the sum bits.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair on a_in/b_in is valid.
- in_ready  output  1  feeder can accept an operand pair.
- a_in  input  WIDTH  operand A, parallel.
- b_in  input  WIDTH  operand B, parallel.
- adder_clr  output  1  one-cycle registered pulse; drives the serial adder's reset to clear its carry.
- a_ser  output  1  current bit of A, LSB first.
- b_ser  output  1  current bit of B, LSB first.
- ser_valid  output  1  a_ser/b_ser carry a real bit this cycle.
- ser_first  output  1  bit 0 of the frame.
- ser_last  output  1  final bit of the frame.
- busy  output  1  a frame is in progress (CLEAR or SHIFT state).

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clk.
- All outputs are registered; no combinational input-to-output paths.
- Reset values: state=IDLE; shift registers=0; bit counter=0; in_ready=0; adder_clr=0; a_ser=b_ser=0; ser_valid=ser_first=ser_last=0; busy=0.
- in_ready rises on the first clock edge after reset deasserts.
- FSM states are IDLE, CLEAR and SHIFT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture a_in/b_in into the shift regs, drop in_ready, go to CLEAR.
  - in_valid without acceptance is ignored; operands are not held across cycles.
- CLEAR (exactly 1 cycle):
  - adder_clr=1 and busy=1; ser_valid=0.
  - Next state is SHIFT with counter=0.
- SHIFT (WIDTH cycles, counter 0..WIDTH-1):
  - ser_valid=1; a_ser/b_ser = LSB of the respective shift register.
  - Shift registers shift right with 0 fill every cycle.
  - ser_first=1 when counter==0; ser_last=1 when counter==WIDTH-1.
  - After the last bit: go to IDLE; in_ready=1 on the following cycle.
- Latency: accept edge -> adder_clr high 1 cycle later -> bit 0 on the next cycle.
- Frame period: WIDTH+2 cycles (IDLE accept + CLEAR + WIDTH SHIFT). Back-to-back frames with in_valid held high have no further gaps.
- a_ser/b_ser are forced to 0 whenever ser_valid=0.
- The counter is wide enough for WIDTH+1 values and never wraps within a frame.
- Reset mid-frame: return immediately to reset values. A partial frame is dropped with no ser_last, and adder_clr is not re-pulsed.
- in_valid asserted while busy is ignored; in_ready=0 guarantees no capture.

Optional Feature:
- Macro: SER_CARRY_FLUSH_EN.
- Defined:
  - SHIFT runs WIDTH+1 cycles; the extra final cycle has a_ser=b_ser=0 and ser_valid=1.
  - ser_last moves to this extra cycle, so the adder emits the carry-out as sum bit WIDTH.
  - Frame period becomes WIDTH+3.
- Undefined: WIDTH bit cycles only; carry-out is discarded.

Decomposition:
- Shared package (serial_pkg):
  - FSM state encoding (IDLE/CLEAR/SHIFT, 2 bits).
  - Default WIDTH constant.
  - Counter-width function clog2(WIDTH+1), used by both the feeder and the downstream sum collector.
- One sub-module: ser_shift_reg (WIDTH-bit parallel-load, right-shift register with load/shift enables and async reset), instantiated twice for A and B.

Test Plan:
- WIDTH=8, A=0x5A, B=0x3C.
  - Required: adder_clr pulse 1 cycle after accept.
  - a_ser=0,1,0,1,1,0,1,0 and b_ser=0,0,1,1,1,1,0,0 over 8 cycles.
  - ser_first on bit 0, ser_last on bit 7; the adder chain yields 0x96.
- in_valid held high with pairs (0x01,0x01) then (0x02,0x03): two frames exactly 10 cycles apart; in_ready low throughout each frame.
- Assert reset at SHIFT bit 3: all outputs 0 within the same cycle; ser_last never seen; in_ready=1 one edge after release.
- in_valid pulsed during SHIFT: no capture; shift regs unchanged; next frame starts only after the IDLE accept.
- With SER_CARRY_FLUSH_EN, A=0xFF, B=0x01: 9 valid cycles, 9th bits 0/0 with ser_last; adder output bit 8 = 1 (sum 0x100).
- Without SER_CARRY_FLUSH_EN, same operands: 8 valid cycles, ser_last on bit 7; collected sum 0x00.
